// File: rtl/fpga_boot_reset_sequencer.sv
// Boot/reset sequencer between clock wizard, reset button and x_heep_system.
// Optional automatic reboot after exit is enabled by defining FPGA_AUTO_REBOOT_EN.
module fpga_boot_reset_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 64,
    parameter int REBOOT_DELAY    = 1024
) (
    input  logic        clk_gen,
    input  logic        rst_n,
    input  logic        pll_locked_i,
    input  logic        sw_rst_i,
    input  logic        boot_select_i,
    input  logic        execute_from_flash_i,
    input  logic        exit_valid_i,
    input  logic [31:0] exit_value_i,
    output logic        sys_rst_no,
    output logic        boot_select_o,
    output logic        execute_from_flash_o,
    output logic [2:0]  state_o,
    output logic        exit_seen_o,
    output logic [31:0] exit_code_o,
    output logic [7:0]  reboot_count_o
);
    typedef enum logic [2:0] {
        ST_WAIT_LOCK   = 3'd0,
        ST_HOLD        = 3'd1,
        ST_SAMPLE      = 3'd2,
        ST_RUN         = 3'd3,
        ST_DONE        = 3'd4,
        ST_REBOOT_WAIT = 3'd5
    } state_e;

    localparam int CNT_MAX = (HOLD_CYCLES > REBOOT_DELAY) ? HOLD_CYCLES : REBOOT_DELAY;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    // Synchronized bit order: {exit_valid, execute_from_flash, boot_select, sw_rst, pll_locked}
    logic [SYNC_STAGES-1:0][4:0] sync_q, sync_d;
    logic [4:0]                  raw_s, sync_s;
    logic                        exit_rise_s;
    logic                        db_level_q, db_level_d;
    logic [DB_W-1:0]             db_cnt_q, db_cnt_d;
    logic                        exit_prev_q, exit_prev_d;
    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        sys_rst_n_q, sys_rst_n_d;
    logic                        boot_select_q, boot_select_d;
    logic                        xip_q, xip_d;
    logic                        exit_seen_q, exit_seen_d;
    logic [31:0]                 exit_code_q, exit_code_d;
    logic [7:0]                  reboot_count_q, reboot_count_d;

    assign raw_s       = {exit_valid_i, execute_from_flash_i, boot_select_i, sw_rst_i, pll_locked_i};
    assign sync_s      = sync_q[SYNC_STAGES-1];
    assign exit_rise_s = sync_s[4] & ~exit_prev_q;

    // Next-state logic: synchronizers, button debounce, sequencing FSM and captured outputs.
    always_comb begin
        sync_d         = {sync_q[SYNC_STAGES-2:0], raw_s};
        db_level_d     = db_level_q;
        db_cnt_d       = db_cnt_q;
        exit_prev_d    = sync_s[4];
        state_d        = state_q;
        cnt_d          = cnt_q;
        boot_select_d  = boot_select_q;
        xip_d          = xip_q;
        exit_seen_d    = exit_seen_q;
        exit_code_d    = exit_code_q;
        reboot_count_d = reboot_count_q;

        if (sync_s[1] == db_level_q) begin
            db_cnt_d = {DB_W{1'b0}};
        end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_level_d = sync_s[1];
            db_cnt_d   = {DB_W{1'b0}};
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end

        // Lock loss beats the button, which beats every normal transition.
        if (!sync_s[0]) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = {CNT_W{1'b0}};
        end else if (db_level_q) begin
            state_d = ST_HOLD;
            cnt_d   = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    state_d = ST_HOLD;
                    cnt_d   = {CNT_W{1'b0}};
                end
                ST_HOLD: begin
                    if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                        state_d = ST_SAMPLE;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    boot_select_d = sync_s[2];
                    xip_d         = sync_s[3];
                    state_d       = ST_RUN;
                end
                ST_RUN: begin
                    if (exit_rise_s) begin
                        exit_code_d = exit_value_i;
                        exit_seen_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
`ifdef FPGA_AUTO_REBOOT_EN
                    state_d = ST_REBOOT_WAIT;
                    cnt_d   = {CNT_W{1'b0}};
`else
                    state_d = ST_DONE;
`endif
                end
                ST_REBOOT_WAIT: begin
`ifdef FPGA_AUTO_REBOOT_EN
                    if (cnt_q == CNT_W'(REBOOT_DELAY - 1)) begin
                        state_d = ST_HOLD;
                        cnt_d   = {CNT_W{1'b0}};
                        if (reboot_count_q != 8'hFF) begin
                            reboot_count_d = reboot_count_q + 8'd1;
                        end else begin
                            reboot_count_d = reboot_count_q;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`else
                    state_d = ST_WAIT_LOCK;
`endif
                end
                default: begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = {CNT_W{1'b0}};
                end
            endcase
        end

        if ((state_d == ST_HOLD) && (state_q != ST_HOLD)) begin
            exit_seen_d = 1'b0;
        end else begin
            exit_seen_d = exit_seen_d;
        end

        // System runs only in RUN and DONE; every other state holds it in reset.
        if ((state_d == ST_RUN) || (state_d == ST_DONE)) begin
            sys_rst_n_d = 1'b1;
        end else begin
            sys_rst_n_d = 1'b0;
        end

`ifndef FPGA_AUTO_REBOOT_EN
        reboot_count_d = 8'd0;
`endif
    end

    // State and output registers.
    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            sync_q         <= '0;
            db_level_q     <= 1'b0;
            db_cnt_q       <= {DB_W{1'b0}};
            exit_prev_q    <= 1'b0;
            state_q        <= ST_WAIT_LOCK;
            cnt_q          <= {CNT_W{1'b0}};
            sys_rst_n_q    <= 1'b0;
            boot_select_q  <= 1'b0;
            xip_q          <= 1'b0;
            exit_seen_q    <= 1'b0;
            exit_code_q    <= 32'd0;
            reboot_count_q <= 8'd0;
        end else begin
            sync_q         <= sync_d;
            db_level_q     <= db_level_d;
            db_cnt_q       <= db_cnt_d;
            exit_prev_q    <= exit_prev_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            sys_rst_n_q    <= sys_rst_n_d;
            boot_select_q  <= boot_select_d;
            xip_q          <= xip_d;
            exit_seen_q    <= exit_seen_d;
            exit_code_q    <= exit_code_d;
            reboot_count_q <= reboot_count_d;
        end
    end

    assign sys_rst_no           = sys_rst_n_q;
    assign boot_select_o        = boot_select_q;
    assign execute_from_flash_o = xip_q;
    assign state_o              = state_q;
    assign exit_seen_o          = exit_seen_q;
    assign exit_code_o          = exit_code_q;
    assign reboot_count_o       = reboot_count_q;

endmodule
